// File: rtl/instr_seq_fx.sv
// instr_seq_fx: instruction sequencer for the fixed-point core.
// It holds the program counter, drives the synchronous instruction ROM
// address and handles jumps, call/return through a small stack, stall,
// halt, and a one-cycle bubble after reset.
// Optional build macro SEQ_STACK_TRAP_EN: when defined, a stack overflow
// or underflow stops the sequencer in FAULT. When undefined, overflow
// overwrites the oldest stack entry and underflow returns to address 0.
//
// state | meaning
// RUN   | fetching and issuing instructions
// HALT  | HLT executed; frozen until rst
// FAULT | stack trap taken; frozen until rst
module instr_seq_fx #(
  parameter int MINSTW = 9,
  parameter int NBOPCO = 6,
  parameter int NBOPER = 9,
  parameter int NBINST = NBOPCO + NBOPER,
  parameter int SDEPTH = 5,
  parameter logic [NBOPCO-1:0] OP_JMP = 6'h10,
  parameter logic [NBOPCO-1:0] OP_JIZ = 6'h11,
  parameter logic [NBOPCO-1:0] OP_CAL = 6'h12,
  parameter logic [NBOPCO-1:0] OP_RET = 6'h13,
  parameter logic [NBOPCO-1:0] OP_HLT = 6'h14
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NBINST-1:0]              instr,
  output logic [MINSTW-1:0]              instr_addr,
  input  logic                           stall,
  input  logic                           acc_zero,
  output logic                           issue,
  output logic [NBOPCO-1:0]              opcode,
  output logic [NBOPER-1:0]              operand,
  output logic [MINSTW-1:0]              pc,
  output logic [$clog2(SDEPTH+1)-1:0]    sp_level,
  output logic                           halted,
  output logic                           fault
);

  localparam int SPW = $clog2(SDEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(SDEPTH);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } state_t;

  state_t            state;
  logic              primed;
  logic [MINSTW-1:0] stack [SDEPTH];

  logic [MINSTW-1:0] pc_inc;
  logic [MINSTW-1:0] target;
  logic [MINSTW-1:0] nxt;
  logic [MINSTW-1:0] stk_top;
  logic [SPW-1:0]    sp_dec;
  logic              is_cal;
  logic              is_ret;
  logic              is_hlt;
  logic              ovf;
  logic              unf;
  logic              trap;

  assign opcode  = instr[NBINST-1:NBOPER];
  assign operand = instr[NBOPER-1:0];
  assign target  = operand[MINSTW-1:0];
  assign pc_inc  = pc + 1'b1;
  assign sp_dec  = sp_level - 1'b1;
  assign is_cal  = (opcode == OP_CAL);
  assign is_ret  = (opcode == OP_RET);
  assign is_hlt  = (opcode == OP_HLT);
  assign ovf     = is_cal && (sp_level == SP_FULL);
  assign unf     = is_ret && (sp_level == '0);
  assign issue   = primed && (state == ST_RUN) && !stall;
  assign halted  = (state == ST_HALT);

`ifdef SEQ_STACK_TRAP_EN
  assign trap  = ovf || unf;
  assign fault = (state == ST_FAULT);
`else
  assign trap  = 1'b0;
  assign fault = 1'b0;
`endif

  // Top-of-stack read; underflow reads as address 0
  always_comb begin
    stk_top = '0;
    if (sp_level != '0) stk_top = stack[sp_dec];
  end

  // Next-PC selection and ROM address
  always_comb begin
    nxt = pc_inc;
    if (trap)                          nxt = pc;
    else if (opcode == OP_JMP)         nxt = target;
    else if (opcode == OP_JIZ)         nxt = acc_zero ? target : pc_inc;
    else if (is_cal)                   nxt = target;
    else if (is_ret)                   nxt = stk_top;
    else if (is_hlt)                   nxt = pc;
    instr_addr = issue ? nxt : pc;
  end

  // Sequencer state, pc and stack pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      primed   <= 1'b0;
      pc       <= '0;
      sp_level <= '0;
    end else if (!primed) begin
      primed <= 1'b1;
    end else if (issue) begin
      if (trap) begin
        state <= ST_FAULT;
      end else begin
        pc <= nxt;
        if (is_hlt) state <= ST_HALT;
        if (is_cal && !ovf) sp_level <= sp_level + 1'b1;
        if (is_ret && !unf) sp_level <= sp_dec;
      end
    end
  end

  // Stack storage; a full push shifts out the oldest entry
  always_ff @(posedge clk) begin
    if (primed && issue && !trap && is_cal) begin
      if (ovf) begin
        for (int i = 0; i < SDEPTH - 1; i++) stack[i] <= stack[i+1];
        stack[SDEPTH-1] <= pc_inc;
      end else begin
        stack[sp_level] <= pc_inc;
      end
    end
  end

endmodule

// File: doc/instr_seq_fx.md
Name: instr_seq_fx

Overview:
- Parametrised instruction sequencer for the fixed-point core: program counter, synchronous instruction fetch, conditional jumps, and a call/return stack of configurable depth.
- Adds what the current fetch path lacks: a stall handshake for multi-cycle datapath ops, halt, a reset bubble with an issue-valid flag, and stack overflow/underflow trapping.
- Sits between the synchronous-read instruction ROM and the instruction decoder.

Parameters:
- MINSTW, 9: instruction address width.
- NBOPCO, 6: opcode width.
- NBOPER, 9: operand width; must be >= MINSTW.
- NBINST, NBOPCO+NBOPER: instruction word width; opcode is the MSBs.
- SDEPTH, 5: call stack entries, >= 1.
- OP_JMP, 6'h10: unconditional jump opcode.
- OP_JIZ, 6'h11: jump-if-accumulator-zero opcode.
- OP_CAL, 6'h12: call opcode.
- OP_RET, 6'h13: return opcode.
- OP_HLT, 6'h14: halt opcode.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- instr  in  NBINST  ROM data; holds the word addressed by instr_addr on the previous edge.
- instr_addr  out  MINSTW  ROM address (combinational next-PC).
- stall  in  1  datapath busy: freeze sequencing.
- acc_zero  in  1  accumulator == 0 flag, sampled for OP_JIZ.
- issue  out  1  opcode/operand valid for the decoder this cycle.
- opcode  out  NBOPCO  instr[NBINST-1:NBOPER].
- operand  out  NBOPER  instr[NBOPER-1:0].
- pc  out  MINSTW  address of the instruction on instr.
- sp_level  out  $clog2(SDEPTH+1)  number of occupied stack entries.
- halted  out  1  HLT executed.
- fault  out  1  stack trap taken.

Behaviour:
- Internal state: RUN, HALT, FAULT, plus a `primed` flag.
- Reset values:
  - state RUN, primed 0, pc 0, sp_level 0.
  - issue 0, halted 0, fault 0.
  - instr_addr 0; stack contents don't-care.
- Reset bubble: the first edge after rst deasserts sets primed=1 only; pc stays 0. issue is 0 while primed=0.
- issue = primed & (state==RUN) & ~stall.
- Next PC (nxt), evaluated when issue=1:
  - OP_JMP: nxt = operand[MINSTW-1:0].
  - OP_JIZ: nxt = operand if acc_zero, else pc+1.
  - OP_CAL: push pc+1, then nxt = operand.
  - OP_RET: pop; nxt = the popped value.
  - OP_HLT: nxt = pc; state goes to HALT.
  - Any other opcode: nxt = pc+1, wrapping modulo 2^MINSTW.
- instr_addr = nxt when issue=1, otherwise pc. The ROM therefore re-presents the current word during stall/HALT/FAULT/bubble.
- pc <= nxt on each edge where issue=1; pc holds otherwise. Single-cycle issue; no delay slots.
- stall=1:
  - No pc change, no push/pop, no state change.
  - opcode/operand stay driven, but issue=0.
  - Stall is sampled every cycle with no latency.
- Stack:
  - LIFO indexed by sp_level.
  - Push writes entry[sp_level] and increments sp_level.
  - Pop reads entry[sp_level-1] and decrements sp_level.
  - Push and pop never occur in the same cycle, since CAL and RET are exclusive opcodes.
- Overflow: CAL with sp_level==SDEPTH. Underflow: RET with sp_level==0. Handling is per the optional feature below.
- HALT and FAULT are sticky until rst. halted=1 in HALT, fault=1 in FAULT. issue stays 0 and instr_addr stays at pc.
- Reset mid-stall, mid-HALT or mid-FAULT returns everything to the reset values asynchronously.

Optional Feature:
- Macro: SEQ_STACK_TRAP_EN.
- Defined:
  - Overflow or underflow moves state to FAULT that edge.
  - pc, sp_level and the stack are unchanged.
  - fault=1 from the next cycle.
- Undefined:
  - Overflow discards the oldest entry: a circular buffer with sp_level saturated at SDEPTH. The call proceeds normally.
  - Underflow yields nxt=0 with sp_level staying 0.
  - fault is tied to 0.

Test Plan:
- Reset bubble: release rst with ROM word0 = NOP:
  - instr_addr 0 and issue 0 in the first cycle.
  - issue=1 and pc=0 in the next cycle.
  - pc then steps 1, 2, 3.
- Jumps:
  - JMP 0x40 at pc 5 → pc=0x40 next cycle.
  - JIZ 0x20 with acc_zero=1 → pc=0x20.
  - JIZ 0x20 with acc_zero=0 → pc+1.
- Call/return: CAL 0x30 at pc 7 → pc=0x30, sp_level=1. RET at 0x32 → pc=8, sp_level=0. Nest 3 calls, then unwind in LIFO order.
- Stall: assert stall for 3 cycles while pc=0x12 holds CAL:
  - pc, instr_addr and sp_level all stay at 0x12 / 0.
  - issue=0.
  - One cycle after release: pc=target, sp_level=1.
- Overflow: 6 nested CALs with SDEPTH=5.
  - With SEQ_STACK_TRAP_EN: fault=1, pc frozen at the 6th CAL, sp_level=5.
  - Without: sp_level=5, and 5 RETs return to the 5 most recent sites.
- Halt/underflow: HLT at pc 9 → halted=1, pc=9 until rst.
  - RET at sp_level 0 with SEQ_STACK_TRAP_EN → fault=1.
  - Same RET without the macro → pc=0.
  - Asserting rst clears halted/fault immediately.
